// File: rtl/sub_32bit_serial_pkg.sv
// Package for the digit-serial subtractor.
// Provides the controller state type, built on the shared state encodings.
`include "sub_serial_defs.vh"

package sub_32bit_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `SUB_ST_IDLE,
    ST_RUN  = `SUB_ST_RUN,
    ST_DONE = `SUB_ST_DONE
  } state_t;

endpackage

// File: rtl/sub_32bit_serial_digit.sv
// Combinational single-digit subtractor: {bout, diff} = a - b - bin.
// Ports:
//   a, b  : DIGIT_W-bit operand digits
//   bin   : borrow into this digit
//   diff  : DIGIT_W-bit difference digit
//   bout  : borrow out of this digit
module sub_digit #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] diff,
  output logic               bout
);

  // One extra bit wide: a negative result leaves the top bit set, which is the borrow.
  logic [DIGIT_W:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
  assign diff = full[DIGIT_W-1:0];
  assign bout = full[DIGIT_W];

endmodule

// File: rtl/sub_serial_defs.vh
// Shared definitions for the digit-serial subtractor.
//   - State encodings for the IDLE / RUN / DONE controller.
//     Encoding 2'd3 is illegal and is decoded as IDLE.
//   - Counter width for an N-digit operation: ceil(log2(N)), minimum 1.
`ifndef SUB_SERIAL_DEFS_VH
`define SUB_SERIAL_DEFS_VH

`define SUB_ST_IDLE 2'd0
`define SUB_ST_RUN  2'd1
`define SUB_ST_DONE 2'd2

`define SUB_CNT_W(n) ((((n) > 1) ? $clog2(n) : 1))

`endif

// File: rtl/sub_32bit_serial.sv
// Digit-serial subtractor: D = A - B - Bin, one DIGIT_W-bit digit per clock,
// least significant digit first, with a Start/Busy/Done handshake.
// Ports:
//   CLK   : clock, all state changes on the rising edge
//   RST   : synchronous active-high reset
//   Start : request, accepted only in IDLE or DONE
//   A, B  : minuend / subtrahend, latched on the accepting edge
//   Bin   : borrow-in, latched on the accepting edge
//   Busy  : high while digits are being processed
//   Done  : one-cycle pulse, result outputs freshly valid
//   D     : difference (held until the next completion)
//   Bout  : final borrow, 1 iff A < B + Bin (unsigned)
//   Zero  : D == 0
//   Ovf   : signed overflow of the subtraction
`include "sub_serial_defs.vh"

module sub_32bit_serial
  import sub_32bit_serial_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Zero,
  output logic             Ovf
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = `SUB_CNT_W(N);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic [DIGIT_W-1:0] dig_diff;
  logic             dig_bout;
  logic             last;

  // The lowest digit of the operand shift registers is always the one being worked on.
  sub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a    (a_sh[DIGIT_W-1:0]),
    .b    (b_sh[DIGIT_W-1:0]),
    .bin  (borrow),
    .diff (dig_diff),
    .bout (dig_bout)
  );

  assign last = (cnt == CW'(N - 1));

  // Result digits enter from the top so that after N shifts digit 0 sits at the bottom.
  generate
    if (N == 1) begin : g_single
      assign acc_next = dig_diff;
    end else begin : g_multi
      assign acc_next = {dig_diff, acc[WIDTH-1:DIGIT_W]};
    end
  endgenerate

  assign Busy = (state == ST_RUN);
  assign Done = (state == ST_DONE);

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; Start is only looked at when no operation is in flight.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: next_state = Start ? ST_RUN : ST_IDLE;
      ST_RUN:  next_state = last ? ST_DONE : ST_RUN;
      ST_DONE: next_state = Start ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand latching, digit stepping and result publication.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      Zero   <= 1'b0;
      Ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= Bin;
            acc    <= '0;
            cnt    <= '0;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          borrow <= dig_bout;
          acc    <= acc_next;
          cnt    <= cnt + CW'(1);
          // Visible outputs change only on the final digit, so they hold during a RUN.
          if (last) begin
            D    <= acc_next;
            Bout <= dig_bout;
            Zero <= (acc_next == '0);
            Ovf  <= (a_msb != b_msb) && (acc_next[WIDTH-1] != a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_32bit_serial.sv
module tb_sub_32bit_serial;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Bin = 1'b0;
  logic        Busy, Done, Bout, Zero, Ovf;
  logic [31:0] D;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } item_t;

  item_t exp_q[$];
  logic [31:0] last_d;

  sub_32bit_serial dut (
    .CLK(CLK), .RST(RST), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Busy(Busy), .Done(Done), .D(D), .Bout(Bout), .Zero(Zero), .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  // Reference 32-bit full adder (ripple, bit by bit).
  function automatic logic [31:0] add32(input logic [31:0] x, input logic [31:0] y, input logic cin);
    logic [31:0] s;
    logic c;
    c = cin;
    for (int i = 0; i < 32; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return s;
  endfunction

  function automatic item_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    item_t it;
    logic [32:0] full;
    full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    it.a = a;
    it.b = b;
    it.bin = bin;
    it.d = full[31:0];
    it.bout = ({1'b0, a} < ({1'b0, b} + {32'd0, bin}));
    it.zero = (full[31:0] == 32'd0);
    it.ovf = (a[31] != b[31]) && (full[31] != a[31]);
    return it;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive one accepted Start and record the expected result.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic bin);
    A = a;
    B = b;
    Bin = bin;
    Start = 1'b1;
    exp_q.push_back(model(a, b, bin));
    step();
    Start = 1'b0;
  endtask

  // Wait for Done (bounded), check latency and results; leaves the bench in the Done cycle.
  task automatic wait_done(input string tag, input int already, input bit full_check);
    int busy_cnt;
    item_t e;
    busy_cnt = already;
    for (int g = 0; g < 30 && Busy; g++) begin
      busy_cnt++;
      step();
    end
    check({tag, "_latency"}, 32'(busy_cnt), 32'd8);
    check({tag, "_done"}, {31'd0, Done}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, Busy}, 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_D"}, D, e.d);
      check({tag, "_Bout"}, {31'd0, Bout}, {31'd0, e.bout});
      if (full_check) begin
        check({tag, "_Zero"}, {31'd0, Zero}, {31'd0, e.zero});
        check({tag, "_Ovf"}, {31'd0, Ovf}, {31'd0, e.ovf});
      end else begin
        check({tag, "_adder"}, add32(D, e.b, e.bin), e.a);
      end
    end
  endtask

  initial begin
    // Reset held two cycles with a Start pulse present.
    RST = 1'b1;
    Start = 1'b1;
    A = 32'h1234_5678;
    B = 32'h0000_0001;
    step();
    step();
    RST = 1'b0;
    Start = 1'b0;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_D", D, 32'd0);
    check("rst_Bout", {31'd0, Bout}, 32'd0);
    check("rst_Zero", {31'd0, Zero}, 32'd0);
    check("rst_Ovf", {31'd0, Ovf}, 32'd0);
    step();
    check("rst_start_ignored", {31'd0, Busy}, 32'd0);

    // Directed vectors.
    launch(32'h0000_0000, 32'h0000_0000, 1'b0);
    wait_done("zero", 0, 1'b1);
    step();
    check("done_pulse", {31'd0, Done}, 32'd0);

    launch(32'h0000_0000, 32'h0000_0001, 1'b0);
    wait_done("neg1_b", 0, 1'b1);
    step();
    launch(32'h0000_0000, 32'h0000_0000, 1'b1);
    wait_done("neg1_bin", 0, 1'b1);
    step();
    launch(32'h8000_0000, 32'h0000_0001, 1'b0);
    wait_done("ovf", 0, 1'b1);
    step();
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("ones", 0, 1'b1);
    step();

    // Start during RUN is ignored; Start in the Done cycle is accepted.
    launch(32'h5555_5555, 32'hAAAA_AAAA, 1'b1);
    step();
    step();
    A = 32'h0000_0001;
    B = 32'h0000_0001;
    Bin = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    wait_done("hs_ignore", 3, 1'b1);
    last_d = D;
    launch(32'h1234_5678, 32'h0000_0078, 1'b0);
    check("hs_b2b_busy", {31'd0, Busy}, 32'd1);
    check("hs_hold_D", D, last_d);
    wait_done("hs_b2b", 0, 1'b1);
    step();

    // Reset in the middle of RUN discards the operation.
    launch(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    step();
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_q.delete();
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_D", D, 32'd0);
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (Done) done_seen++;
        step();
      end
      check("midrst_no_done", 32'(done_seen), 32'd0);
    end

    // Random vectors, checked against the reference adder and unsigned compare.
    for (int i = 0; i < 200; i++) begin
      launch($urandom, $urandom, 1'($urandom_range(1, 0)));
      wait_done("rand", 0, 1'b0);
      if (i % 2 == 0) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_32bit_serial.md
Name: sub_32bit_serial

Overview:
- Digit-serial 32-bit subtractor: computes D = A - B - Bin, one DIGIT_W-bit digit per clock, LSB digit first.
- Inverse-direction companion to the team's combinational 32-bit full adder; for any input set, D + B + Bin == A (mod 2^WIDTH).
- Trades latency for area in the datapath, using a Start/Busy/Done handshake.
- Flags: borrow-out, zero and signed overflow.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of DIGIT_W.
- DIGIT_W, 4, bits processed per cycle.
- N = WIDTH/DIGIT_W is a derived localparam (8 by default), not a parameter.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- Start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend; latched on the edge that accepts Start.
- B  input  WIDTH  subtrahend; latched on the edge that accepts Start.
- Bin  input  1  borrow-in; latched on the edge that accepts Start.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse; result valid.
- D  output  WIDTH  difference.
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).
- Zero  output  1  D == 0.
- Ovf  output  1  signed overflow: (A[msb] != B[msb]) && (D[msb] != A[msb]).

Behaviour:
- Reset (RST=1 at an edge):
  - state = IDLE.
  - Busy, Done, D, Bout, Zero, Ovf all 0.
  - Operand, shift and borrow registers cleared.
- Reset mid-RUN: the in-flight operation is discarded and Done never pulses for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 at an edge latches A, B, Bin into working registers, clears the digit counter, and moves to RUN.
  - Start=0: stay in IDLE.
- RUN, per edge:
  - Subtract digit k: A_k - B_k - borrow.
  - Shift the DIGIT_W result bits into the result register from the top.
  - Update borrow and increment the counter.
  - After digit N-1 is processed, move to DONE.
  - Start is ignored in RUN; operands are not re-latched.
- Result update, on the edge leaving RUN:
  - D, Bout, Zero and Ovf update together.
  - Done=1 for exactly the next cycle.
- Latency: Done is high during the cycle following the Nth edge after the accepting edge (8 edges by default).
- DONE:
  - Start=1 is accepted, giving back-to-back operation; the next state is RUN.
  - Otherwise the next state is IDLE.
- Busy=1 only in RUN; Busy and Done are never high together.
- Result holding: D, Bout, Zero and Ovf hold their values until the next completion or reset. They do not change during a subsequent RUN.
- Width rules:
  - Per-digit subtraction is DIGIT_W+1 bits wide; the top bit is the borrow.
  - Final borrow = Bout.
  - Ovf is computed from the latched A and B MSBs and the final D MSB.
- Boundaries:
  - 0 - 0 - 1 gives D = all ones and Bout = 1.
  - A == B with Bin = 0 gives Zero = 1 and Bout = 0.
  - When DIGIT_W == WIDTH (N = 1), the block still takes one RUN cycle.

Decomposition:
- Shared header "sub_serial_defs.vh" holds:
  - state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2 (2'd3 is illegal and decodes to IDLE);
  - the counter width macro, ceil(log2(N)) with a minimum of 1.
- One natural combinational sub-module, sub_digit: DIGIT_W-bit A - B - bin giving diff and bout.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- Reset: hold RST=1 for 2 cycles, then release -> Busy=0, Done=0, D=0, Bout=0, Zero=0, Ovf=0. A Start pulse with RST=1 is ignored.
- A=0000_0000, B=0000_0000, Bin=0, Start pulse -> Busy high for 8 cycles, then Done pulse (1 cycle) with D=0000_0000, Bout=0, Zero=1, Ovf=0.
- A=0000_0000, B=0000_0001, Bin=0 -> D=FFFF_FFFF, Bout=1, Zero=0, Ovf=0. Repeat with B=0, Bin=1 -> same result.
- A=8000_0000, B=0000_0001, Bin=0 -> D=7FFF_FFFF, Bout=0, Ovf=1. Then A=FFFF_FFFF, B=FFFF_FFFF, Bin=1 -> D=FFFF_FFFF, Bout=1, Ovf=0.
- Handshake:
  - Start with A=5555_5555, B=AAAA_AAAA, Bin=1.
  - Re-assert Start with A=1, B=1 during cycle 3 of RUN.
  - Required: ignored; result D=AAAA_AAAA, Bout=1, Ovf=1.
  - Then Start in the Done cycle -> accepted, next result follows 8 cycles later.
- Reset mid-RUN at cycle 4 -> Busy=0 next cycle, no Done pulse, D=0.
- 200 random vectors -> check D + B + Bin == A (mod 2^32) using the team's 32-bit full adder as the reference model. Also check that Bout matches the unsigned compare.
